// File: rtl/imem_access_arbiter.sv
// Arbiter and access sequencer for the single-ported instruction memory.
// Round-robins fetch and loader requests, rejects bad addresses, times reads.
module imem_access_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_grant,
  output logic              fetch_valid,
  output logic              fetch_fault,
  output logic [31:0]       fetch_data,
  input  logic              load_req,
  input  logic              load_write,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_wdata,
  output logic              load_grant,
  output logic              load_valid,
  output logic              load_fault,
  output logic [31:0]       load_rdata,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FAULT, WAIT, RESP} state_t;
  typedef enum logic {PORT_FETCH, PORT_LOAD} port_t;

  localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

  state_t              state, state_nxt;
  port_t               last_grant, cur_port;
  logic                cur_write;
  logic [ADDR_W-1:0]   cur_addr;
  logic [31:0]         cur_wdata;
  logic [3:0]          cnt;
  logic                idle_ok, any_grant, sel_fault;
  logic [31:0]         sel_addr;

  // Grants are combinational; gating with rst_n keeps them quiet while reset is held.
  assign idle_ok     = (state == IDLE) && rst_n;
  assign fetch_grant = idle_ok && fetch_req && (!load_req || last_grant == PORT_LOAD);
  assign load_grant  = idle_ok && load_req && (!fetch_req || last_grant == PORT_FETCH);
  assign any_grant   = fetch_grant || load_grant;
  assign sel_addr    = fetch_grant ? fetch_addr : load_addr;
  assign sel_fault   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_grant) state_nxt = sel_fault ? FAULT : WAIT;
      FAULT:   state_nxt = IDLE;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_enable  = (state == WAIT) && (cnt == CNT_START);
  assign mem_write   = mem_enable && cur_write;
  assign mem_addr    = mem_enable ? cur_addr : '0;
  assign mem_wdata   = mem_write ? cur_wdata : '0;
  assign fetch_valid = ((state == RESP) || (state == FAULT)) && (cur_port == PORT_FETCH);
  assign load_valid  = ((state == RESP) || (state == FAULT)) && (cur_port == PORT_LOAD);
  assign fetch_fault = (state == FAULT) && (cur_port == PORT_FETCH);
  assign load_fault  = (state == FAULT) && (cur_port == PORT_LOAD);
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_LOAD;
      cur_port   <= PORT_FETCH;
      cur_write  <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cnt        <= '0;
      fetch_data <= '0;
      load_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (any_grant) begin
        last_grant <= fetch_grant ? PORT_FETCH : PORT_LOAD;
        cur_port   <= fetch_grant ? PORT_FETCH : PORT_LOAD;
        cur_write  <= load_grant && load_write;
        cur_addr   <= sel_addr[ADDR_W+1:2];
        cur_wdata  <= load_wdata;
        cnt        <= CNT_START;
        // A rejected access answers in the very next cycle with zero data.
        if (sel_fault) begin
          if (fetch_grant) fetch_data <= '0;
          else             load_rdata <= '0;
        end
      end
      if (state == WAIT) begin
        if (cnt == 4'd0) begin
          if (cur_port == PORT_FETCH) fetch_data <= mem_rdata;
          else                        load_rdata <= cur_write ? '0 : mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule
